// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - two-input gate block truth-table sequencer and checker
//
// Purpose: after start, drives the four {a,b} combinations 00,01,10,11 onto the
// gate block. Each vector is held SETTLE_CYCLES cycles and then the six gate
// outputs are sampled once. Failing vectors are recorded per vector and counted.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   run request, honoured only in IDLE or DONE
//   y_bus     in   [0]not [1]and [2]or [3]xor [4]nor [5]nand
//   a, b      out  registered gate inputs
//   busy      out  high in SETTLE and SAMPLE
//   done      out  high in DONE
//   pass      out  done with zero failing vectors
//   err_count out  number of failing vectors (0..4)
//   fail_vec  out  bit v set if vector v mismatched
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] y_bus,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic [5:0] exp_y;
  logic       mismatch;
  logic [1:0] v_next;

  // Expected outputs are taken from the registered inputs actually driven.
  assign exp_y    = {~(a_q & b_q), ~(a_q | b_q), a_q ^ b_q, a_q | b_q, a_q & b_q, ~a_q};
  assign mismatch = (y_bus != exp_y);
  assign v_next   = v_q + 2'd1;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          v_d     = 2'd0;
          cnt_d   = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // A vector counts once no matter how many output bits differ.
        if (mismatch) begin
          fail_d[v_q] = 1'b1;
          err_d       = err_q + 3'd1;
        end
        if (v_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          v_d     = v_next;
          a_d     = v_next[1];
          b_d     = v_next[0];
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next-state values so they line up
    // with the state they describe.
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == 3'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb/tb_gate_truth_table_checker.sv - directed self-checking bench for gate_truth_table_checker
module tb_gate_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [5:0] y0, y1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] fail0, fail1;
  int         mode0, mode1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start0), .y_bus(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fail0)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_bus(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fail1)
  );

  // Gate block stand-in: 0 golden, 1 xor stuck at 0, 2 all outputs stuck at 0.
  function automatic logic [5:0] gate_model(input logic ia, input logic ib, input int mode);
    logic [5:0] y;
    y = {~(ia & ib), ~(ia | ib), ia ^ ib, ia | ib, ia & ib, ~ia};
    if (mode == 1) y[3] = 1'b0;
    if (mode == 2) y = 6'h00;
    return y;
  endfunction

  always_comb y0 = gate_model(a0, b0, mode0);
  always_comb y1 = gate_model(a1, b1, mode1);

  int         run_sel = 0;
  logic       cur_done, cur_busy;
  logic [1:0] cur_ab;
  logic [2:0] cur_err;
  always_comb begin
    cur_done = (run_sel == 0) ? done0 : done1;
    cur_busy = (run_sel == 0) ? busy0 : busy1;
    cur_ab   = (run_sel == 0) ? {a0, b0} : {a1, b1};
    cur_err  = (run_sel == 0) ? err0 : err1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic val);
    if (sel == 0) start0 = val;
    else start1 = val;
  endtask

  // Starts a run, optionally re-pulses start at cycle pulse_at, and reports
  // edges from acceptance to done, busy samples, the {a,b} change sequence and
  // err_count right after acceptance.
  task automatic run_vectors(input int sel, input int pulse_at, output int cycles,
                             output int busy_cnt, output logic [7:0] seq,
                             output logic [2:0] err_first);
    logic [1:0] last;
    run_sel = sel;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
    cycles    = 0;
    busy_cnt  = 0;
    err_first = cur_err;
    seq       = {6'b0, cur_ab};
    last      = cur_ab;
    while (!cur_done && cycles < 200) begin
      if (cur_busy) busy_cnt++;
      if (cycles == pulse_at) set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      cycles++;
      if (cur_ab !== last) begin
        seq  = {seq[5:0], cur_ab};
        last = cur_ab;
      end
    end
    if (cycles >= 200) check_eq("run_timeout", 32'(cycles), 32'd0);
  endtask

  int         cyc, bcnt;
  logic [7:0] seq;
  logic [2:0] e_first;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; mode0 = 0; mode1 = 0;
    #1;
    check_eq("reset_outputs", {a0, b0, busy0, done0, pass0, err0, fail0}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: golden run
    run_vectors(0, -1, cyc, bcnt, seq, e_first);
    check_eq("t1_cycles", 32'(cyc), 32'd12);
    check_eq("t1_busy_cycles", 32'(bcnt), 32'd12);
    check_eq("t1_ab_sequence", 32'(seq), 32'h1B);
    check_eq("t1_done_pass", {done0, pass0, busy0}, 32'b110);
    check_eq("t1_err", 32'(err0), 32'd0);
    check_eq("t1_fail_vec", 32'(fail0), 32'd0);

    // 2: xor stuck low
    mode0 = 1;
    run_vectors(0, -1, cyc, bcnt, seq, e_first);
    check_eq("t2_fail_vec", 32'(fail0), 32'b0110);
    check_eq("t2_err", 32'(err0), 32'd2);
    check_eq("t2_done_pass", {done0, pass0}, 32'b10);

    // 3: all outputs stuck low
    mode0 = 2;
    run_vectors(0, -1, cyc, bcnt, seq, e_first);
    check_eq("t3_restart_clears_err", 32'(e_first), 32'd0);
    check_eq("t3_fail_vec", 32'(fail0), 32'b1111);
    check_eq("t3_err", 32'(err0), 32'd4);
    check_eq("t3_pass", 32'(pass0), 32'd0);

    // 4: start re-pulsed during vector 1 is ignored
    mode0 = 0;
    run_vectors(0, 4, cyc, bcnt, seq, e_first);
    check_eq("t4_cycles", 32'(cyc), 32'd12);
    check_eq("t4_ab_sequence", 32'(seq), 32'h1B);
    check_eq("t4_done_pass", {done0, pass0}, 32'b11);

    // 5: reset while vector 2 is settling
    run_sel = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("t5_mid_ab", {a0, b0, busy0}, 32'b101);
    rst = 1'b1;
    #1;
    check_eq("t5_async_clear", {a0, b0, busy0, done0, pass0, err0, fail0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vectors(0, -1, cyc, bcnt, seq, e_first);
    check_eq("t5_rerun_cycles", 32'(cyc), 32'd12);
    check_eq("t5_rerun_seq", 32'(seq), 32'h1B);
    check_eq("t5_rerun_pass", {done0, pass0, err0, fail0}, 32'b11_000_0000);

    // 6: SETTLE_CYCLES=1 instance, failing run then golden restart from DONE
    mode1 = 2;
    run_vectors(1, -1, cyc, bcnt, seq, e_first);
    check_eq("t6_fail_cycles", 32'(cyc), 32'd8);
    check_eq("t6_fail_vec", 32'(fail1), 32'b1111);
    check_eq("t6_fail_err", 32'(err1), 32'd4);
    mode1 = 0;
    run_vectors(1, -1, cyc, bcnt, seq, e_first);
    check_eq("t6_restart_err_cleared", 32'(e_first), 32'd0);
    check_eq("t6_cycles", 32'(cyc), 32'd8);
    check_eq("t6_ab_sequence", 32'(seq), 32'h1B);
    check_eq("t6_pass", {done1, pass1, err1, fail1}, 32'b11_000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
